pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the fetch/decode/execute pipeline latches: drives enable/clr for the decode-stage
//  parsed-instruction registers and the execute latch. Resolves three hazards:
//   - load-use stall
//   - taken-branch squash
//   - multi-cycle mul/div hold
//  Keeps a saturating stall-cycle counter and a sticky mul/div timeout flag.
// PARAMETERS
//  OP_ALU      5'b00000  opcode of R-type ALU instructions
//  OP_LW       5'b01000  opcode of load word
//  ALUOP_MUL   5'b00110  aluop selecting multiply
//  ALUOP_DIV   5'b00111  aluop selecting divide
//  MD_TIMEOUT  64        max MD_WAIT cycles before abort (must be >= 2)
// PORTS
//  clk            in   1   pipeline clock, all state updates on rising edge
//  ctrl_reset_n   in   1   synchronous active-low reset
//  d_rs, d_rt     in   5   source regs of instruction in decode latch
//  d_uses_rs      in   1   decode instruction reads rs
//  d_uses_rt      in   1   decode instruction reads rt
//  x_opcode       in   5   opcode of instruction in execute latch
//  x_aluop        in   5   aluop of instruction in execute latch
//  x_rd           in   5   destination reg of instruction in execute latch
//  branch_taken   in   1   execute resolved a taken branch/jump this cycle
//  md_ready       in   1   mul/div unit result valid (1-cycle pulse)
//  fetch_enable   out  1   PC/fetch latch advance
//  decode_enable  out  1   decode parsed-instruction registers load
//  decode_clr     out  1   decode registers load NOP
//  execute_enable out  1   execute latch load
//  execute_clr    out  1   execute latch load NOP (bubble)
//  md_start       out  1   1-cycle start pulse to mul/div unit
//  md_busy        out  1   high while state==MD_WAIT
//  md_error       out  1   sticky: mul/div timed out
//  stall_cycles   out  16  saturating count of cycles with decode_enable==0
// BEHAVIOUR
//  Reset:
//   - While ctrl_reset_n==0 at a clock edge: state<=RUN, md_cnt<=0, md_error<=0, stall_cycles<=0.
//   - Combinational outputs are forced while ctrl_reset_n==0: enables=0, decode_clr=1,
//     execute_clr=1, md_start=0, md_busy=0.
//  Decode terms:
//   - x_is_md = (x_opcode==OP_ALU) && (x_aluop==ALUOP_MUL || x_aluop==ALUOP_DIV).
//   - load_use = (x_opcode==OP_LW) && x_rd!=0 && ((d_uses_rs && d_rs==x_rd) || (d_uses_rt && d_rt==x_rd)).
//  FSM states: RUN, MD_WAIT. Outputs are a combinational function of state + inputs; zero latency.
//  RUN, priority order:
//   1 branch_taken:
//     - fetch_en=1, decode_en=1, decode_clr=1, execute_en=1, execute_clr=1 (squash 2 younger instrs).
//     - x_is_md and load_use are ignored this cycle.
//   2 x_is_md:
//     - md_start=1; fetch_en=decode_en=execute_en=0; clr=0.
//     - next state MD_WAIT, md_cnt<=0.
//   3 load_use:
//     - fetch_en=0, decode_en=0, execute_en=1, execute_clr=1.
//     - One bubble; clears itself as the load advances.
//   4 else: all enables=1, clr=0.
//  MD_WAIT:
//   - md_busy=1; branch_taken is ignored; md_cnt increments each cycle.
//   - md_ready=1: all enables=1 that cycle (mul/div instr leaves execute); next state RUN.
//   - md_ready=0 and md_cnt==MD_TIMEOUT-1: md_error<=1; enables=1 that cycle; next state RUN.
//   - Otherwise: all enables=0, clr=0; stay in MD_WAIT.
//   - md_start is never asserted in MD_WAIT.
//  Back-to-back mul/div:
//   - The next x_is_md is seen in RUN the cycle after release and issues a fresh md_start.
//  stall_cycles:
//   - +1 on each non-reset cycle with decode_enable==0.
//   - Holds at 16'hFFFF (no wrap).
//  md_ready while in RUN is ignored. Reset mid-MD_WAIT returns to RUN immediately; no md_start.
// TESTING
//  T1 reset held 3 clks -> enables 0, decode_clr=1, execute_clr=1;
//     release -> all enables 1, stall_cycles=0.
//  T2 x_opcode=OP_LW, x_rd=5, d_rs=5, d_uses_rs=1
//     -> one cycle fetch_en=decode_en=0, execute_clr=1, stall_cycles=1;
//     same with x_rd=0 -> no stall.
//  T3 x MUL, md_ready pulsed 33 clks after md_start
//     -> md_start exactly 1 cycle; md_busy 33 cycles; enables 0 until md_ready cycle.
//  T4 branch_taken=1 together with load_use=1 and x_is_md=1
//     -> decode_clr=execute_clr=1, md_start=0, state stays RUN.
//  T5 MUL with md_ready never asserted -> md_error=1 after 64 MD_WAIT cycles, state RUN;
//     md_error stays 1 until reset.
//  T6 force 70000 stall cycles -> stall_cycles saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard sequencer.
// master = datapath side (reports decode/execute contents), slave = sequencer.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic        d_uses_rs;
  logic        d_uses_rt;
  logic [4:0]  x_opcode;
  logic [4:0]  x_aluop;
  logic [4:0]  x_rd;
  logic        branch_taken;
  logic        md_ready;
  logic        fetch_enable;
  logic        decode_enable;
  logic        decode_clr;
  logic        execute_enable;
  logic        execute_clr;
  logic        md_start;
  logic        md_busy;
  logic        md_error;
  logic [15:0] stall_cycles;

  modport master (
    output d_rs, d_rt, d_uses_rs, d_uses_rt, x_opcode, x_aluop, x_rd,
           branch_taken, md_ready,
    input  fetch_enable, decode_enable, decode_clr, execute_enable,
           execute_clr, md_start, md_busy, md_error, stall_cycles
  );

  modport slave (
    input  d_rs, d_rt, d_uses_rs, d_uses_rt, x_opcode, x_aluop, x_rd,
           branch_taken, md_ready,
    output fetch_enable, decode_enable, decode_clr, execute_enable,
           execute_clr, md_start, md_busy, md_error, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Fetch/decode/execute latch sequencer: load-use stall, taken-branch squash and
// multi-cycle mul/div hold with timeout, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter logic [4:0] OP_ALU     = 5'b00000,
  parameter logic [4:0] OP_LW      = 5'b01000,
  parameter logic [4:0] ALUOP_MUL  = 5'b00110,
  parameter logic [4:0] ALUOP_DIV  = 5'b00111,
  parameter int         MD_TIMEOUT = 64
) (
  input  logic clk,
  input  logic ctrl_reset_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  typedef enum logic [0:0] {RUN, MD_WAIT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             md_err_q, md_err_d;
  logic [15:0]      stall_q, stall_d;

  logic x_is_md, load_use;
  logic fetch_en, dec_en, dec_clr, exe_en, exe_clr, start, busy;

  assign x_is_md  = (hz.x_opcode == OP_ALU) &&
                    ((hz.x_aluop == ALUOP_MUL) || (hz.x_aluop == ALUOP_DIV));
  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = (hz.x_opcode == OP_LW) && (hz.x_rd != 5'd0) &&
                    ((hz.d_uses_rs && (hz.d_rs == hz.x_rd)) ||
                     (hz.d_uses_rt && (hz.d_rt == hz.x_rd)));

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    md_err_d = md_err_q;
    fetch_en = 1'b0;
    dec_en   = 1'b0;
    dec_clr  = 1'b0;
    exe_en   = 1'b0;
    exe_clr  = 1'b0;
    start    = 1'b0;
    busy     = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.branch_taken) begin
          fetch_en = 1'b1;
          dec_en   = 1'b1;
          dec_clr  = 1'b1;
          exe_en   = 1'b1;
          exe_clr  = 1'b1;
        end else if (x_is_md) begin
          start    = 1'b1;
          state_d  = MD_WAIT;
          md_cnt_d = '0;
        end else if (load_use) begin
          // Bubble into execute while fetch/decode hold the dependent instr.
          exe_en   = 1'b1;
          exe_clr  = 1'b1;
        end else begin
          fetch_en = 1'b1;
          dec_en   = 1'b1;
          exe_en   = 1'b1;
        end
      end
      MD_WAIT: begin
        busy     = 1'b1;
        md_cnt_d = md_cnt_q + 1'b1;
        if (hz.md_ready || (md_cnt_q == CNT_LAST)) begin
          fetch_en = 1'b1;
          dec_en   = 1'b1;
          exe_en   = 1'b1;
          state_d  = RUN;
          if (!hz.md_ready) md_err_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (!ctrl_reset_n) begin
      fetch_en = 1'b0;
      dec_en   = 1'b0;
      dec_clr  = 1'b1;
      exe_en   = 1'b0;
      exe_clr  = 1'b1;
      start    = 1'b0;
      busy     = 1'b0;
    end

    stall_d = stall_q;
    if (!dec_en && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!ctrl_reset_n) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
      md_err_q <= 1'b0;
      stall_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      md_err_q <= md_err_d;
      stall_q  <= stall_d;
    end
  end

  assign hz.fetch_enable   = fetch_en;
  assign hz.decode_enable  = dec_en;
  assign hz.decode_clr     = dec_clr;
  assign hz.execute_enable = exe_en;
  assign hz.execute_clr    = exe_clr;
  assign hz.md_start       = start;
  assign hz.md_busy        = busy;
  assign hz.md_error       = md_err_q;
  assign hz.stall_cycles   = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// scored against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam logic [4:0] OP_ALU    = 5'b00000;
  localparam logic [4:0] OP_LW     = 5'b01000;
  localparam logic [4:0] OP_OTHER  = 5'b00011;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;
  localparam int         TMO       = 64;

  // Output vector order: fetch, dec_en, dec_clr, exe_en, exe_clr, start, busy, error
  localparam logic [7:0] V_RESET = 8'b00101000;
  localparam logic [7:0] V_FLOW  = 8'b11010000;
  localparam logic [7:0] V_SQ    = 8'b11111000;
  localparam logic [7:0] V_START = 8'b00000100;
  localparam logic [7:0] V_LU    = 8'b00011000;
  localparam logic [7:0] V_WAIT  = 8'b00000010;
  localparam logic [7:0] V_REL   = 8'b11010010;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bit m_md;
  int m_wait;
  bit m_err;
  int m_stall;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl dut (
    .clk          (clk),
    .ctrl_reset_n (rst_n),
    .hz           (bus)
  );

  logic [7:0] obs;
  assign obs = {bus.fetch_enable, bus.decode_enable, bus.decode_clr, bus.execute_enable,
                bus.execute_clr, bus.md_start, bus.md_busy, bus.md_error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected outputs for the current cycle from the hazard rules.
  function automatic logic [7:0] model_out();
    bit xmd, lu, rel;
    xmd = (bus.x_opcode == OP_ALU) && (bus.x_aluop == ALUOP_MUL || bus.x_aluop == ALUOP_DIV);
    lu  = (bus.x_opcode == OP_LW) && (bus.x_rd != 0) &&
          ((bus.d_uses_rs && bus.d_rs == bus.x_rd) || (bus.d_uses_rt && bus.d_rt == bus.x_rd));
    if (!rst_n) return V_RESET | {7'd0, m_err};
    if (m_md) begin
      rel = bus.md_ready || (m_wait == TMO - 1);
      return {rel, rel, 1'b0, rel, 1'b0, 1'b0, 1'b1, m_err};
    end
    if (bus.branch_taken) return V_SQ | {7'd0, m_err};
    if (xmd) return V_START | {7'd0, m_err};
    if (lu) return V_LU | {7'd0, m_err};
    return V_FLOW | {7'd0, m_err};
  endfunction

  task automatic clock_cycle();
    logic [7:0] e;
    e = model_out();
    @(posedge clk);
    if (!rst_n) begin
      m_md = 0; m_wait = 0; m_err = 0; m_stall = 0;
    end else begin
      if (!e[6]) m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
      if (m_md) begin
        if (e[7]) begin
          if (!bus.md_ready) m_err = 1;
          m_md = 0;
        end else m_wait++;
      end else if (e[2]) begin
        m_md = 1; m_wait = 0;
      end
    end
    #1;
  endtask

  task automatic set_neutral();
    bus.d_rs = 5'd1; bus.d_rt = 5'd2; bus.d_uses_rs = 1'b1; bus.d_uses_rt = 1'b1;
    bus.x_opcode = OP_OTHER; bus.x_aluop = 5'd0; bus.x_rd = 5'd9;
    bus.branch_taken = 1'b0; bus.md_ready = 1'b0;
  endtask

  task automatic set_x(input logic [4:0] op, input logic [4:0] aluop, input logic [4:0] rd);
    bus.x_opcode = op; bus.x_aluop = aluop; bus.x_rd = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_neutral();
    for (int i = 0; i < 3; i++) begin
      clock_cycle();
      #1;
      checks++;
      if (obs !== V_RESET) begin errors++; $display("FAIL reset_outputs: got %b want %b", obs, V_RESET); end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== V_FLOW) begin errors++; $display("FAIL reset_release: got %b want %b", obs, V_FLOW); end
    checks++;
    if (bus.stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cycles); end
    clock_cycle();
  endtask

  task automatic test_load_use();
    set_x(OP_LW, 5'd0, 5'd5); bus.d_rs = 5'd5; bus.d_uses_rs = 1'b1;
    #1;
    checks++;
    if (obs !== V_LU) begin errors++; $display("FAIL load_use_rs: got %b want %b", obs, V_LU); end
    clock_cycle();
    set_x(OP_ALU, 5'd0, 5'd5);
    #1;
    checks++;
    if (obs !== V_FLOW) begin errors++; $display("FAIL load_use_clear: got %b want %b", obs, V_FLOW); end
    checks++;
    if (bus.stall_cycles !== 16'd1) begin errors++; $display("FAIL load_use_stall: got %0d want 1", bus.stall_cycles); end
    clock_cycle();
    set_x(OP_LW, 5'd0, 5'd7); bus.d_rt = 5'd7; bus.d_uses_rt = 1'b1; bus.d_uses_rs = 1'b0;
    #1;
    checks++;
    if (obs !== V_LU) begin errors++; $display("FAIL load_use_rt: got %b want %b", obs, V_LU); end
    clock_cycle();
    set_x(OP_LW, 5'd0, 5'd7); bus.d_rt = 5'd7; bus.d_uses_rt = 1'b0; bus.d_uses_rs = 1'b1;
    #1;
    checks++;
    if (obs !== V_FLOW) begin errors++; $display("FAIL load_use_unused: got %b want %b", obs, V_FLOW); end
    clock_cycle();
    set_x(OP_LW, 5'd0, 5'd0); bus.d_rs = 5'd0; bus.d_uses_rs = 1'b1;
    #1;
    checks++;
    if (obs !== V_FLOW) begin errors++; $display("FAIL load_use_r0: got %b want %b", obs, V_FLOW); end
    checks++;
    if (bus.stall_cycles !== 16'd2) begin errors++; $display("FAIL load_use_stall2: got %0d want 2", bus.stall_cycles); end
    clock_cycle();
    set_neutral();
  endtask

  task automatic test_mul_hold();
    int busy_n, s0;
    logic [7:0] w;
    busy_n = 0;
    s0 = m_stall;
    set_x(OP_ALU, ALUOP_MUL, 5'd4);
    #1;
    checks++;
    if (obs !== V_START) begin errors++; $display("FAIL mul_start: got %b want %b", obs, V_START); end
    clock_cycle();
    for (int k = 1; k <= 33; k++) begin
      bus.md_ready = (k == 33);
      #1;
      if (bus.md_busy === 1'b1) busy_n++;
      w = (k == 33) ? V_REL : V_WAIT;
      checks++;
      if (obs !== w) begin errors++; $display("FAIL mul_wait[%0d]: got %b want %b", k, obs, w); end
      clock_cycle();
    end
    set_neutral();
    #1;
    checks++;
    if (obs !== V_FLOW) begin errors++; $display("FAIL mul_after: got %b want %b", obs, V_FLOW); end
    checks++;
    if (busy_n !== 33) begin errors++; $display("FAIL mul_busy_len: got %0d want 33", busy_n); end
    checks++;
    if (bus.stall_cycles !== 16'(s0 + 33)) begin
      errors++; $display("FAIL mul_stall: got %0d want %0d", bus.stall_cycles, s0 + 33);
    end
    clock_cycle();
  endtask

  task automatic test_branch_priority();
    set_x(OP_LW, 5'd0, 5'd3); bus.d_rs = 5'd3; bus.d_uses_rs = 1'b1; bus.branch_taken = 1'b1;
    #1;
    checks++;
    if (obs !== V_SQ) begin errors++; $display("FAIL branch_vs_lu: got %b want %b", obs, V_SQ); end
    clock_cycle();
    set_x(OP_ALU, ALUOP_DIV, 5'd3); bus.branch_taken = 1'b1;
    #1;
    checks++;
    if (obs !== V_SQ) begin errors++; $display("FAIL branch_vs_md: got %b want %b", obs, V_SQ); end
    clock_cycle();
    set_neutral();
    #1;
    checks++;
    if (obs !== V_FLOW) begin errors++; $display("FAIL branch_stays_run: got %b want %b", obs, V_FLOW); end
    clock_cycle();
  endtask

  task automatic test_back_to_back();
    set_x(OP_ALU, ALUOP_MUL, 5'd6);
    #1;
    checks++;
    if (obs !== V_START) begin errors++; $display("FAIL b2b_start1: got %b want %b", obs, V_START); end
    clock_cycle();
    bus.md_ready = 1'b1;
    #1;
    checks++;
    if (obs !== V_REL) begin errors++; $display("FAIL b2b_rel1: got %b want %b", obs, V_REL); end
    clock_cycle();
    bus.md_ready = 1'b0; set_x(OP_ALU, ALUOP_DIV, 5'd7);
    #1;
    checks++;
    if (obs !== V_START) begin errors++; $display("FAIL b2b_start2: got %b want %b", obs, V_START); end
    clock_cycle();
    for (int k = 0; k < 3; k++) begin
      bus.md_ready = (k == 2); bus.branch_taken = (k == 0);
      #1;
      checks++;
      if (obs !== ((k == 2) ? V_REL : V_WAIT)) begin
        errors++; $display("FAIL b2b_wait2[%0d]: got %b", k, obs);
      end
      clock_cycle();
    end
    set_neutral(); bus.md_ready = 1'b1;
    #1;
    checks++;
    if (obs !== V_FLOW) begin errors++; $display("FAIL ready_in_run: got %b want %b", obs, V_FLOW); end
    clock_cycle();
    set_neutral();
  endtask

  task automatic test_timeout();
    logic [7:0] w;
    set_x(OP_ALU, ALUOP_MUL, 5'd8);
    #1;
    checks++;
    if (obs !== V_START) begin errors++; $display("FAIL tmo_start: got %b want %b", obs, V_START); end
    clock_cycle();
    for (int k = 1; k <= TMO; k++) begin
      #1;
      w = (k == TMO) ? V_REL : V_WAIT;
      checks++;
      if (obs !== w) begin errors++; $display("FAIL tmo_wait[%0d]: got %b want %b", k, obs, w); end
      clock_cycle();
    end
    set_neutral();
    #1;
    checks++;
    if (obs !== (V_FLOW | 8'd1)) begin errors++; $display("FAIL tmo_error: got %b want %b", obs, V_FLOW | 8'd1); end
    for (int k = 0; k < 4; k++) clock_cycle();
    set_x(OP_ALU, ALUOP_MUL, 5'd8);
    clock_cycle();
    bus.md_ready = 1'b1;
    clock_cycle();
    set_neutral();
    #1;
    checks++;
    if (bus.md_error !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", bus.md_error); end
    clock_cycle();
  endtask

  task automatic test_reset_mid_wait();
    set_x(OP_ALU, ALUOP_MUL, 5'd2);
    clock_cycle();
    for (int k = 0; k < 4; k++) clock_cycle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== (V_RESET | 8'd1)) begin errors++; $display("FAIL rst_mid_wait: got %b want %b", obs, V_RESET | 8'd1); end
    clock_cycle();
    #1;
    checks++;
    if (obs !== V_RESET) begin errors++; $display("FAIL rst_clears_err: got %b want %b", obs, V_RESET); end
    rst_n = 1'b1; set_neutral();
    #1;
    checks++;
    if (obs !== V_FLOW) begin errors++; $display("FAIL rst_back_run: got %b want %b", obs, V_FLOW); end
    checks++;
    if (bus.stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_stall_zero: got %0d want 0", bus.stall_cycles); end
    clock_cycle();
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(99) >= 3);
      bus.d_rs = 5'($urandom_range(3)); bus.d_rt = 5'($urandom_range(3));
      bus.d_uses_rs = 1'($urandom); bus.d_uses_rt = 1'($urandom);
      case ($urandom_range(3))
        0: bus.x_opcode = OP_ALU;
        1: bus.x_opcode = OP_LW;
        2: bus.x_opcode = OP_LW;
        default: bus.x_opcode = OP_OTHER;
      endcase
      case ($urandom_range(3))
        0: bus.x_aluop = ALUOP_MUL;
        1: bus.x_aluop = ALUOP_DIV;
        default: bus.x_aluop = 5'($urandom_range(5));
      endcase
      bus.x_rd = 5'($urandom_range(3));
      bus.branch_taken = ($urandom_range(9) == 0);
      bus.md_ready = ($urandom_range(19) < 3);
      #1;
      e = model_out();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rand_out[%0d]: got %b want %b", n, obs, e); end
      checks++;
      if (bus.stall_cycles !== 16'(m_stall)) begin
        errors++; $display("FAIL rand_stall[%0d]: got %0d want %0d", n, bus.stall_cycles, m_stall);
      end
      clock_cycle();
    end
    rst_n = 1'b1; bus.md_ready = 1'b1; set_neutral(); bus.md_ready = 1'b1;
    clock_cycle();
    bus.md_ready = 1'b0;
  endtask

  task automatic test_saturate();
    rst_n = 1'b0; set_neutral();
    clock_cycle();
    rst_n = 1'b1;
    set_x(OP_LW, 5'd0, 5'd5); bus.d_rs = 5'd5; bus.d_uses_rs = 1'b1;
    for (int n = 0; n < 70000; n++) clock_cycle();
    #1;
    checks++;
    if (bus.stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL stall_saturate: got %h want ffff", bus.stall_cycles); end
    checks++;
    if (obs !== V_LU) begin errors++; $display("FAIL stall_sat_outputs: got %b want %b", obs, V_LU); end
    set_neutral();
    clock_cycle();
    #1;
    checks++;
    if (bus.stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL stall_hold: got %h want ffff", bus.stall_cycles); end
  endtask

  initial begin
    checks = 0; errors = 0;
    m_md = 0; m_wait = 0; m_err = 0; m_stall = 0;
    rst_n = 1'b0;
    set_neutral();
    test_reset();
    test_load_use();
    test_mul_hold();
    test_branch_priority();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
